// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings for the pipelined RV32I-subset control unit.
// Holds the opcode constants, ALU operation codes, immediate format and
// writeback source selects used by the decoder and the pipeline registers.
package pipeline_control_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluCtl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10
    } resultSrc_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrc_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational Decode-stage decoder: main decoder (opcode -> control bits)
// followed by the ALU decoder (ALUOp/funct3/funct7b5 -> ALU operation).
// Inputs : opD, funct3D, funct7b5D
// Outputs: regWriteD, resultSrcD, memWriteD, jumpD, branchD, aluControlD,
//          aluSrcD, immSrcD
module cu_decoder
    import pipeline_control_unit_pkg::*;
(
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic       funct7b5D,
    output logic       regWriteD,
    output logic [1:0] resultSrcD,
    output logic       memWriteD,
    output logic       jumpD,
    output logic       branchD,
    output logic [2:0] aluControlD,
    output logic       aluSrcD,
    output logic [1:0] immSrcD
);

    aluOp_e aluOp;

    always_comb begin
        regWriteD  = 1'b0;
        immSrcD    = IMM_I;
        aluSrcD    = 1'b0;
        memWriteD  = 1'b0;
        resultSrcD = RES_ALU;
        branchD    = 1'b0;
        aluOp      = ALUOP_ADD;
        jumpD      = 1'b0;
        case (opD)
            OP_LOAD: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = RES_MEM;
            end
            OP_STORE: begin
                immSrcD   = IMM_S;
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
            end
            OP_RTYPE: begin
                regWriteD = 1'b1;
                aluOp     = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                immSrcD = IMM_B;
                branchD = 1'b1;
                aluOp   = ALUOP_SUB;
            end
            OP_IALU: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluOp     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                regWriteD  = 1'b1;
                immSrcD    = IMM_J;
                resultSrcD = RES_PC4;
                jumpD      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        aluControlD = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControlD = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3D)
                    // opD[5] separates R-type from I-type, so ADDI never subtracts
                    3'b000:  aluControlD = (funct7b5D & opD[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControlD = ALU_SLT;
                    3'b110:  aluControlD = ALU_OR;
                    3'b111:  aluControlD = ALU_AND;
                    default: aluControlD = ALU_ADD;
                endcase
            end
            default: aluControlD = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Control unit for a 5-stage pipelined RV32I-subset core. Decodes in D and
// carries control through the D->E, E->M and M->W registers; derives the
// branch/jump redirect PCSrcE from the Execute control and ZeroE.
// Inputs : clock, reset (async, active-low), opD, funct3D, funct7b5D,
//          FlushE (clears D->E register), ZeroE
// Outputs: ImmSrcD (comb), PCSrcE (comb), ALUControlE, ALUSrcBE,
//          ResultSrcEb0, MemWriteM, RegWriteM, RegWriteW, ResultSrcW
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic       funct7b5D,
    input  logic       FlushE,
    input  logic       ZeroE,
    output logic [1:0] ImmSrcD,
    output logic       PCSrcE,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcBE,
    output logic       ResultSrcEb0,
    output logic       MemWriteM,
    output logic       RegWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW
);

    logic       regWriteD, memWriteD, jumpD, branchD, aluSrcD;
    logic [1:0] resultSrcD;
    logic [2:0] aluControlD;

    logic       regWriteE, memWriteE, jumpE, branchE;
    logic [1:0] resultSrcE;
    logic [1:0] resultSrcM;

    cu_decoder uDecoder (
        .opD         (opD),
        .funct3D     (funct3D),
        .funct7b5D   (funct7b5D),
        .regWriteD   (regWriteD),
        .resultSrcD  (resultSrcD),
        .memWriteD   (memWriteD),
        .jumpD       (jumpD),
        .branchD     (branchD),
        .aluControlD (aluControlD),
        .aluSrcD     (aluSrcD),
        .immSrcD     (ImmSrcD)
    );

    // Decode -> Execute
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regWriteE   <= 1'b0;
            resultSrcE  <= '0;
            memWriteE   <= 1'b0;
            jumpE       <= 1'b0;
            branchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcBE    <= 1'b0;
        end else if (FlushE) begin
            regWriteE   <= 1'b0;
            resultSrcE  <= '0;
            memWriteE   <= 1'b0;
            jumpE       <= 1'b0;
            branchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcBE    <= 1'b0;
        end else begin
            regWriteE   <= regWriteD;
            resultSrcE  <= resultSrcD;
            memWriteE   <= memWriteD;
            jumpE       <= jumpD;
            branchE     <= branchD;
            ALUControlE <= aluControlD;
            ALUSrcBE    <= aluSrcD;
        end
    end

    // Execute -> Memory
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            resultSrcM <= '0;
            MemWriteM  <= 1'b0;
        end else begin
            RegWriteM  <= regWriteE;
            resultSrcM <= resultSrcE;
            MemWriteM  <= memWriteE;
        end
    end

    // Memory -> Writeback
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= resultSrcM;
        end
    end

    assign ResultSrcEb0 = resultSrcE[0];
    assign PCSrcE       = (branchE & ZeroE) | jumpE;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    logic       clock;
    logic       reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D;
    logic       FlushE;
    logic       ZeroE;
    logic [1:0] ImmSrcD;
    logic       PCSrcE;
    logic [2:0] ALUControlE;
    logic       ALUSrcBE;
    logic       ResultSrcEb0;
    logic       MemWriteM;
    logic       RegWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;

    int unsigned assertions = 0;
    int unsigned failures   = 0;

    pipeline_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .opD          (opD),
        .funct3D      (funct3D),
        .funct7b5D    (funct7b5D),
        .FlushE       (FlushE),
        .ZeroE        (ZeroE),
        .ImmSrcD      (ImmSrcD),
        .PCSrcE       (PCSrcE),
        .ALUControlE  (ALUControlE),
        .ALUSrcBE     (ALUSrcBE),
        .ResultSrcEb0 (ResultSrcEb0),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opD       = op;
        funct3D   = f3;
        funct7b5D = f7;
    endtask

    task automatic test_reset();
        reset = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
        setInstr(7'b0000000, 3'b000, 1'b0);
        tick(); tick();
        reset = 1'b1;
        #1;
        assertions++;
        if ({ALUControlE, ALUSrcBE, ResultSrcEb0, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, PCSrcE, ImmSrcD} !== 14'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ALUC=%b SrcB=%b RS0=%b MW=%b RWM=%b RWW=%b RSW=%b PC=%b Imm=%b expected all 0",
                     ALUControlE, ALUSrcBE, ResultSrcEb0, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, PCSrcE, ImmSrcD);
        end
        // build up in-flight state: lw in M, jal in E
        setInstr(7'b0000011, 3'b010, 1'b0); tick();
        setInstr(7'b1101111, 3'b000, 1'b0); tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({RegWriteM, PCSrcE} !== 2'b11) begin
            failures++;
            $display("FAIL reset_prefill: got RegWriteM=%b PCSrcE=%b expected 1 1", RegWriteM, PCSrcE);
        end
        #2 reset = 1'b0;
        #1;
        assertions++;
        if ({RegWriteM, PCSrcE, ALUControlE, RegWriteW} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async: got RegWriteM=%b PCSrcE=%b ALUC=%b RegWriteW=%b expected 0", RegWriteM, PCSrcE, ALUControlE, RegWriteW);
        end
        // reset wins over normal loading and FlushE=0
        setInstr(7'b0000011, 3'b010, 1'b0);
        tick();
        assertions++;
        if ({ALUSrcBE, ResultSrcEb0} !== 2'b00) begin
            failures++;
            $display("FAIL reset_priority: got ALUSrcBE=%b RS0=%b expected 0 0", ALUSrcBE, ResultSrcEb0);
        end
        setInstr(7'b0000000, 3'b000, 1'b0);
        reset = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_rtype_add();
        setInstr(7'b0110011, 3'b000, 1'b0);
        #1;
        assertions++;
        if (ImmSrcD !== 2'b00) begin
            failures++; $display("FAIL add_imm: got %b expected 00", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({ALUControlE, ALUSrcBE, ResultSrcEb0} !== 5'b00000) begin
            failures++; $display("FAIL add_E: got ALUC=%b SrcB=%b RS0=%b expected 000 0 0", ALUControlE, ALUSrcBE, ResultSrcEb0);
        end
        tick();
        assertions++;
        if ({RegWriteM, MemWriteM} !== 2'b10) begin
            failures++; $display("FAIL add_M: got RegWriteM=%b MemWriteM=%b expected 1 0", RegWriteM, MemWriteM);
        end
        tick();
        assertions++;
        if ({RegWriteW, ResultSrcW} !== 3'b100) begin
            failures++; $display("FAIL add_W: got RegWriteW=%b ResultSrcW=%b expected 1 00", RegWriteW, ResultSrcW);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [9];
        logic [2:0] f3s [9];
        logic       f7s [9];
        logic [2:0] expC[9];
        logic       expB[9];
        ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b1100011, 7'b0000011};
        f3s = '{3'b000,     3'b110,     3'b111,     3'b010,     3'b000,     3'b110,     3'b001,     3'b000,     3'b010};
        f7s = '{1'b1,       1'b0,       1'b0,       1'b0,       1'b1,       1'b0,       1'b1,       1'b1,       1'b1};
        expC = '{3'b001,    3'b011,     3'b010,     3'b101,     3'b000,     3'b011,     3'b000,     3'b001,     3'b000};
        expB = '{1'b0,      1'b0,       1'b0,       1'b0,       1'b1,       1'b1,       1'b1,       1'b0,       1'b1};
        for (int i = 0; i < 9; i++) begin
            setInstr(ops[i], f3s[i], f7s[i]);
            tick();
            assertions++;
            if ({ALUControlE, ALUSrcBE} !== {expC[i], expB[i]}) begin
                failures++;
                $display("FAIL alu_op[%0d] op=%b f3=%b f7=%b: got ALUC=%b SrcB=%b expected %b %b",
                         i, ops[i], f3s[i], f7s[i], ALUControlE, ALUSrcBE, expC[i], expB[i]);
            end
        end
        setInstr(7'b0000000, 3'b000, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_lw();
        setInstr(7'b0100011, 3'b010, 1'b0);
        #1;
        setInstr(7'b0000011, 3'b010, 1'b0);
        #1;
        assertions++;
        if (ImmSrcD !== 2'b00) begin
            failures++; $display("FAIL lw_imm: got %b expected 00", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({ALUSrcBE, ResultSrcEb0} !== 2'b11) begin
            failures++; $display("FAIL lw_E: got SrcB=%b RS0=%b expected 1 1", ALUSrcBE, ResultSrcEb0);
        end
        tick(); tick();
        assertions++;
        if ({RegWriteW, ResultSrcW} !== 3'b101) begin
            failures++; $display("FAIL lw_W: got RegWriteW=%b ResultSrcW=%b expected 1 01", RegWriteW, ResultSrcW);
        end
    endtask

    task automatic test_sw();
        setInstr(7'b0100011, 3'b010, 1'b0);
        #1;
        assertions++;
        if (ImmSrcD !== 2'b01) begin
            failures++; $display("FAIL sw_imm: got %b expected 01", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        tick();
        assertions++;
        if ({MemWriteM, RegWriteM} !== 2'b10) begin
            failures++; $display("FAIL sw_M: got MemWriteM=%b RegWriteM=%b expected 1 0", MemWriteM, RegWriteM);
        end
        tick();
        assertions++;
        if ({RegWriteW, MemWriteM} !== 2'b00) begin
            failures++; $display("FAIL sw_after: got RegWriteW=%b MemWriteM=%b expected 0 0", RegWriteW, MemWriteM);
        end
    endtask

    task automatic test_beq();
        setInstr(7'b1100011, 3'b000, 1'b0);
        ZeroE = 1'b0;
        #1;
        assertions++;
        if (ImmSrcD !== 2'b10) begin
            failures++; $display("FAIL beq_imm: got %b expected 10", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({ALUControlE, PCSrcE} !== 4'b0010) begin
            failures++; $display("FAIL beq_notaken: got ALUC=%b PCSrcE=%b expected 001 0", ALUControlE, PCSrcE);
        end
        ZeroE = 1'b1;
        #1;
        assertions++;
        if (PCSrcE !== 1'b1) begin
            failures++; $display("FAIL beq_taken: got %b expected 1", PCSrcE);
        end
        tick();
        assertions++;
        if (PCSrcE !== 1'b0) begin
            failures++; $display("FAIL beq_gone: got %b expected 0", PCSrcE);
        end
        ZeroE = 1'b0;
    endtask

    task automatic test_jal();
        setInstr(7'b1101111, 3'b000, 1'b0);
        #1;
        assertions++;
        if (ImmSrcD !== 2'b11) begin
            failures++; $display("FAIL jal_imm: got %b expected 11", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        ZeroE = 1'b0;
        #1;
        assertions++;
        if (PCSrcE !== 1'b1) begin
            failures++; $display("FAIL jal_zero0: got %b expected 1", PCSrcE);
        end
        ZeroE = 1'b1;
        #1;
        assertions++;
        if (PCSrcE !== 1'b1) begin
            failures++; $display("FAIL jal_zero1: got %b expected 1", PCSrcE);
        end
        ZeroE = 1'b0;
        tick(); tick();
        assertions++;
        if ({RegWriteW, ResultSrcW} !== 3'b110) begin
            failures++; $display("FAIL jal_W: got RegWriteW=%b ResultSrcW=%b expected 1 10", RegWriteW, ResultSrcW);
        end
    endtask

    task automatic test_flush();
        ZeroE = 1'b1;
        setInstr(7'b1100011, 3'b000, 1'b0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({ALUControlE, PCSrcE} !== 4'b0000) begin
            failures++; $display("FAIL flush_beq: got ALUC=%b PCSrcE=%b expected 000 0", ALUControlE, PCSrcE);
        end
        setInstr(7'b1101111, 3'b000, 1'b0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        assertions++;
        if (PCSrcE !== 1'b0) begin
            failures++; $display("FAIL flush_jal: got %b expected 0", PCSrcE);
        end
        ZeroE = 1'b0;
        // lw already in E must continue while the following sw is flushed
        setInstr(7'b0000011, 3'b010, 1'b0);
        tick();
        setInstr(7'b0100011, 3'b010, 1'b0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({RegWriteM, MemWriteM, ALUSrcBE, ResultSrcEb0} !== 4'b1000) begin
            failures++; $display("FAIL flush_lw_M: got RWM=%b MWM=%b SrcB=%b RS0=%b expected 1 0 0 0",
                                 RegWriteM, MemWriteM, ALUSrcBE, ResultSrcEb0);
        end
        tick();
        assertions++;
        if ({RegWriteW, ResultSrcW, RegWriteM, MemWriteM} !== 5'b10100) begin
            failures++; $display("FAIL flush_bubble: got RWW=%b RSW=%b RWM=%b MWM=%b expected 1 01 0 0",
                                 RegWriteW, ResultSrcW, RegWriteM, MemWriteM);
        end
        tick(); tick();
    endtask

    task automatic test_unknown_op();
        ZeroE = 1'b1;
        setInstr(7'b0110111, 3'b000, 1'b1);
        #1;
        assertions++;
        if (ImmSrcD !== 2'b00) begin
            failures++; $display("FAIL unk_imm: got %b expected 00", ImmSrcD);
        end
        tick();
        setInstr(7'b0000000, 3'b000, 1'b0);
        assertions++;
        if ({ALUControlE, ALUSrcBE, ResultSrcEb0, PCSrcE} !== 6'b0) begin
            failures++; $display("FAIL unk_E: got ALUC=%b SrcB=%b RS0=%b PC=%b expected 0",
                                 ALUControlE, ALUSrcBE, ResultSrcEb0, PCSrcE);
        end
        tick(); tick();
        assertions++;
        if ({RegWriteW, ResultSrcW} !== 3'b000) begin
            failures++; $display("FAIL unk_W: got RWW=%b RSW=%b expected 0 00", RegWriteW, ResultSrcW);
        end
        ZeroE = 1'b0;
    endtask

    task automatic test_back_to_back();
        ZeroE = 1'b0;
        setInstr(7'b0000011, 3'b010, 1'b0); tick();
        setInstr(7'b0100011, 3'b010, 1'b0); tick();
        assertions++;
        if ({ALUSrcBE, ResultSrcEb0, RegWriteM, MemWriteM} !== 4'b1010) begin
            failures++; $display("FAIL b2b_c2: got SrcB=%b RS0=%b RWM=%b MWM=%b expected 1 0 1 0",
                                 ALUSrcBE, ResultSrcEb0, RegWriteM, MemWriteM);
        end
        setInstr(7'b0110011, 3'b000, 1'b1); tick();
        assertions++;
        if ({ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW} !== 8'b001_1_0_1_01) begin
            failures++; $display("FAIL b2b_c3: got ALUC=%b MWM=%b RWM=%b RWW=%b RSW=%b expected 001 1 0 1 01",
                                 ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW);
        end
        setInstr(7'b1101111, 3'b000, 1'b0); tick();
        assertions++;
        if ({PCSrcE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW} !== 6'b1_1_0_0_00) begin
            failures++; $display("FAIL b2b_c4: got PC=%b RWM=%b MWM=%b RWW=%b RSW=%b expected 1 1 0 0 00",
                                 PCSrcE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW);
        end
        setInstr(7'b0000000, 3'b000, 1'b0); tick();
        assertions++;
        if ({PCSrcE, RegWriteW, ResultSrcW} !== 4'b0_1_00) begin
            failures++; $display("FAIL b2b_c5: got PC=%b RWW=%b RSW=%b expected 0 1 00", PCSrcE, RegWriteW, ResultSrcW);
        end
        tick();
        assertions++;
        if ({RegWriteW, ResultSrcW} !== 3'b110) begin
            failures++; $display("FAIL b2b_c6: got RWW=%b RSW=%b expected 1 10", RegWriteW, ResultSrcW);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_alu_ops();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_flush();
        test_unknown_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
